hdr_frame_reader: RTL and testbench

- Read-side counterpart of the tone-mapping writer. It fetches tone-mapped RGB565 frames from SDRAM as 128-bit words: 8 pixels per word, 4 address units per word.
- It unpacks each word into a per-pixel stream for the display path.
- Frames are double-buffered. The block always reads the buffer the writer is not currently filling; the writer indicates which buffer it is on via hdr_last_frame.
- Sits between the RAM arbiter read port and the VGA output stage.

---
 rtl/hdr_frame_reader.sv | 165 ++++++++++++++++
 tb/tb_hdr_frame_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hdr_frame_reader.sv
// Double-buffered HDR frame reader: fetches 128-bit RGB565 words from SDRAM and streams them out pixel by pixel.
// Optional build macro HDR_RD_UNDERRUN_CNT_EN adds underrun_cnt, a saturating count of starved cycles.
//   state | meaning
//   IDLE  | no frame active, no requests, pixel_valid low
//   FETCH | may issue the next word read when FIFO space and arbiter allow
//   WAIT  | one read outstanding, waiting for rd_valid
//   DRAIN | every word received, emptying the FIFO to the display
module hdr_frame_reader #(
    parameter logic [24:0] BASE0      = 25'hE1000,
    parameter logic [24:0] BASE1      = 25'h106800,
    parameter int          WORDS      = 38400,
    parameter int          ADDR_STEP  = 4,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          wr_last_frame,
    input  logic          ram_busy,
    output logic          rd_req,
    output logic [24:0]   rd_address,
    input  logic [127:0]  rd_data,
    input  logic          rd_valid,
    input  logic          pixel_ready,
    output logic          pixel_valid,
    output logic [4:0]    pix_red,
    output logic [5:0]    pix_green,
    output logic [4:0]    pix_blue,
    output logic          frame_done,
    output logic          underrun
`ifdef HDR_RD_UNDERRUN_CNT_EN
    ,
    output logic [15:0]   underrun_cnt
`endif
);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = PW + 1;
    localparam int WCW = $clog2(WORDS + 1);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAIN} state_t;
    state_t state, state_nxt;

    logic [127:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr, rd_ptr_nxt;
    logic [CW-1:0]  fifo_count, count_nxt;
    logic [2:0]     pix_idx, idx_nxt;
    logic [WCW-1:0] words_left;
    logic           outstanding, stale;
    logic           xfer, pop, accept, issue, last_xfer, starve, valid_nxt;
    logic [127:0]   head_nxt;
    logic [15:0]    half;

    always_comb begin
        xfer      = pixel_valid && pixel_ready;
        pop       = xfer && (pix_idx == 3'd7);
        accept    = rd_valid && outstanding && !stale;
        issue     = (state == FETCH) && !ram_busy && !outstanding
                    && ((fifo_count + CW'(outstanding)) < CW'(FIFO_DEPTH))
                    && (words_left != '0);
        last_xfer = (state == DRAIN) && pop && (fifo_count == CW'(1));
        starve    = pixel_ready && !pixel_valid && ((state == FETCH) || (state == WAIT));

        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            FETCH:   if (issue) state_nxt = WAIT;
            WAIT:    if (accept) state_nxt = (words_left != '0) ? FETCH : DRAIN;
            DRAIN:   if (last_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (frame_start) state_nxt = FETCH;

        count_nxt = fifo_count;
        if (accept && !pop)
            count_nxt = fifo_count + CW'(1);
        else if (!accept && pop)
            count_nxt = fifo_count - CW'(1);
        rd_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;
        idx_nxt    = xfer ? pix_idx + 3'd1 : pix_idx;
        if (frame_start) begin
            count_nxt  = '0;
            rd_ptr_nxt = '0;
            idx_nxt    = '0;
        end

        // A word pushed into an empty (or just-emptied) FIFO becomes the head immediately.
        head_nxt  = (accept && (wr_ptr == rd_ptr_nxt)) ? rd_data : fifo_mem[rd_ptr_nxt];
        half      = head_nxt[{idx_nxt, 4'b0000} +: 16];
        valid_nxt = (count_nxt != '0) && (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) fifo_mem[wr_ptr] <= rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_req      <= 1'b0;
            rd_address  <= BASE0;
            words_left  <= '0;
            outstanding <= 1'b0;
            stale       <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            pix_idx     <= '0;
            pixel_valid <= 1'b0;
            pix_red     <= '0;
            pix_green   <= '0;
            pix_blue    <= '0;
            frame_done  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            rd_req     <= 1'b0;
            frame_done <= 1'b0;
            if (frame_start) begin
                rd_address  <= wr_last_frame ? BASE0 : BASE1;
                words_left  <= WCW'(WORDS);
                wr_ptr      <= '0;
                // A read still in flight belongs to the old frame; its data must be dropped.
                outstanding <= outstanding && !rd_valid;
                stale       <= outstanding && !rd_valid;
                underrun    <= 1'b0;
            end else begin
                if (issue) begin
                    rd_req      <= 1'b1;
                    outstanding <= 1'b1;
                    words_left  <= words_left - WCW'(1);
                end
                if (rd_valid && outstanding) begin
                    outstanding <= 1'b0;
                    stale       <= 1'b0;
                end
                if (accept) begin
                    wr_ptr     <= wr_ptr + PW'(1);
                    rd_address <= rd_address + 25'(ADDR_STEP);
                end
                if (starve) underrun <= 1'b1;
                frame_done <= last_xfer;
            end
            rd_ptr      <= rd_ptr_nxt;
            fifo_count  <= count_nxt;
            pix_idx     <= idx_nxt;
            pixel_valid <= valid_nxt;
            pix_red     <= valid_nxt ? half[7:3] : 5'd0;
            pix_green   <= valid_nxt ? {half[2:0], half[15:13]} : 6'd0;
            pix_blue    <= valid_nxt ? half[12:8] : 5'd0;
        end
    end

`ifdef HDR_RD_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || frame_start)
            underrun_cnt <= '0;
        else if (starve && (underrun_cnt != 16'hFFFF))
            underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_hdr_frame_reader.sv
// Directed bench for hdr_frame_reader with a fixed-latency memory responder and a pixel scoreboard.
// Runs with a short frame (TW words) so every scenario completes quickly.
module tb_hdr_frame_reader;
    localparam int          TW  = 6;
    localparam logic [24:0] B0  = 25'hE1000;
    localparam logic [24:0] B1  = 25'h106800;
    localparam logic [127:0] PAT = 128'h0123_4567_89AB_CDEF_F800_001F_07E0_FFFF;

    logic         clk = 1'b0;
    logic         rst, frame_start, wr_last_frame, ram_busy, pixel_ready;
    logic         rd_req, rd_valid, pixel_valid, frame_done, underrun;
    logic [24:0]  rd_address;
    logic [127:0] rd_data;
    logic [4:0]   pix_red, pix_blue;
    logic [5:0]   pix_green;
`ifdef HDR_RD_UNDERRUN_CNT_EN
    logic [15:0]  underrun_cnt;
`endif

    hdr_frame_reader #(.WORDS(TW)) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .wr_last_frame (wr_last_frame),
        .ram_busy      (ram_busy),
        .rd_req        (rd_req),
        .rd_address    (rd_address),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .pixel_ready   (pixel_ready),
        .pixel_valid   (pixel_valid),
        .pix_red       (pix_red),
        .pix_green     (pix_green),
        .pix_blue      (pix_blue),
        .frame_done    (frame_done),
        .underrun      (underrun)
`ifdef HDR_RD_UNDERRUN_CNT_EN
        ,
        .underrun_cnt  (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [24:0] pat_addr;

    function automatic logic [127:0] mem_word(input logic [24:0] a);
        logic [127:0] w;
        if (a == pat_addr) return PAT;
        for (int i = 0; i < 8; i++)
            w[16*i +: 16] = a[24:9] + a[15:0] + 16'(i * 4099);
        return w;
    endfunction

    // Expected display fields of pixel k: lo byte feeds red/green-high, hi byte green-low/blue.
    function automatic logic [15:0] exp_pix(input logic [127:0] w, input int k);
        logic [7:0] lo, hi;
        lo = w[16*k +: 8];
        hi = w[16*k+8 +: 8];
        return {lo[7:3], lo[2:0], hi[7:5], hi[4:0]};
    endfunction

    int          lat;
    bit          inflight, stale;
    logic [15:0] exp_q[$];
    logic [24:0] resp_addr;
    int          cyc = 0;
    int          rv_first, first_pv_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        rd_valid = 1'b0;
        rd_data  = '0;
        inflight = 1'b0;
        stale    = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_req && !inflight) begin
                resp_addr = rd_address;
                inflight  = 1'b1;
                repeat (lat - 1) @(negedge clk);
                rd_data  = mem_word(resp_addr);
                rd_valid = 1'b1;
                if (stale) stale = 1'b0;
                else begin
                    for (int k = 0; k < 8; k++) exp_q.push_back(exp_pix(rd_data, k));
                    if (rv_first < 0) rv_first = cyc;
                end
                @(negedge clk);
                rd_valid = 1'b0;
                inflight = 1'b0;
            end
        end
    end

    int          req_n, xfer_n, cap_n;
    logic [24:0] last_addr;
    logic [15:0] cap [4];

    always @(negedge clk) begin
        if (rd_req) begin
            req_n++;
            last_addr = rd_address;
        end
        if (pixel_valid && first_pv_cyc < 0) first_pv_cyc = cyc;
        if (pixel_valid && pixel_ready) begin
            if (cap_n < 4) cap[cap_n[1:0]] = {pix_red, pix_green, pix_blue};
            cap_n++;
            xfer_n++;
            if (exp_q.size() == 0) check_val("pix_extra", 1, 0);
            else check_val("pix_stream", {pix_red, pix_green, pix_blue}, exp_q.pop_front());
        end
    end

    task automatic start_frame(input logic wlf);
        @(negedge clk);
        wr_last_frame = wlf;
        frame_start   = 1'b1;
        stale         = inflight;
        exp_q.delete();
        req_n = 0; xfer_n = 0; cap_n = 0;
        rv_first = -1; first_pv_cyc = -1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_req(input string tag, input logic [24:0] exp_addr);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rd_req) break;
        end
        check_val({tag, "_seen"}, rd_req, 1);
        check_val({tag, "_addr"}, rd_address, exp_addr);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        check_val({tag, "_done"}, seen, 1);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, frame_done, 0);
        check_val({tag, "_idle_valid"}, pixel_valid, 0);
        check_val({tag, "_req_count"}, req_n, TW);
        check_val({tag, "_xfer_count"}, xfer_n, TW * 8);
        check_val({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; wr_last_frame = 1'b0;
        ram_busy = 1'b0; pixel_ready = 1'b0;
        lat = 3; pat_addr = '1;
        req_n = 0; xfer_n = 0; cap_n = 0; rv_first = -1; first_pv_cyc = -1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check_val("rst_rd_req", rd_req, 0);
        check_val("rst_rd_address", rd_address, B0);
        check_val("rst_pixel_valid", pixel_valid, 0);
        check_val("rst_pix", {pix_red, pix_green, pix_blue}, 0);
        check_val("rst_frame_done", frame_done, 0);
        check_val("rst_underrun", underrun, 0);
`ifdef HDR_RD_UNDERRUN_CNT_EN
        check_val("rst_underrun_cnt", underrun_cnt, 0);
`endif
        repeat (5) @(negedge clk);
        check_val("idle_no_req", req_n, 0);

        // Frame A: buffer 0, known pattern in the first word, display always ready
        pat_addr = B0; lat = 3; pixel_ready = 1'b1;
        start_frame(1'b1);
        wait_req("a_first", B0);
        wait_req("a_second", B0 + 25'd4);
        check_val("a_pv_latency", first_pv_cyc - rv_first, 1);
        wait_done("a");
        check_val("a_last_addr", last_addr, B0 + 25'(4 * (TW - 1)));
        check_val("a_unpack_p0", cap[0], 16'hFFFF);
        check_val("a_unpack_p1", cap[1], 16'hE007);
        check_val("a_unpack_p2", cap[2], 16'h1F00);
        check_val("a_unpack_p3", cap[3], 16'h00F8);
        repeat (5) @(negedge clk);
        check_val("a_no_req_after_done", req_n, TW);

        // Frame B: buffer 1, arbiter busy then display stalled
        pat_addr = '1; pixel_ready = 1'b0; ram_busy = 1'b1;
        start_frame(1'b0);
        repeat (10) @(negedge clk);
        check_val("b_busy_no_req", req_n, 0);
        ram_busy = 1'b0;
        wait_req("b_first", B1);
        wait_req("b_second", B1 + 25'd4);
        repeat (40) @(negedge clk);
        check_val("b_fifo_full_reqs", req_n, 4);
        check_val("b_head_valid", pixel_valid, 1);
        check_val("b_head_pixel", {pix_red, pix_green, pix_blue}, exp_pix(mem_word(B1), 0));
        pixel_ready = 1'b1;
        wait_done("b");
        check_val("b_last_addr", last_addr, B1 + 25'(4 * (TW - 1)));
        check_val("b_no_underrun", underrun, 0);

        // Frame C: abort while the first read of a buffer-0 frame is in flight
        lat = 10;
        start_frame(1'b1);
        wait_req("c_old", B0);
        repeat (3) @(negedge clk);
        start_frame(1'b0);
        wait_req("c_new", B1);
        check_val("c_fifo_restart_empty", pixel_valid, 0);
        wait_done("c");

        // Frame D: long memory latency with a display that wants pixels for 10 cycles
        lat = 20; pixel_ready = 1'b0;
        start_frame(1'b1);
        wait_req("d_first", B0);
        pixel_ready = 1'b1;
        repeat (10) @(negedge clk);
        pixel_ready = 1'b0;
        check_val("d_underrun", underrun, 1);
`ifdef HDR_RD_UNDERRUN_CNT_EN
        check_val("d_underrun_cnt", underrun_cnt, 10);
`endif

        // Frame E: a new frame clears the starvation record
        lat = 3;
        start_frame(1'b0);
        check_val("e_underrun_clr", underrun, 0);
`ifdef HDR_RD_UNDERRUN_CNT_EN
        check_val("e_underrun_cnt_clr", underrun_cnt, 0);
`endif
        wait_req("e_first", B1);
        pixel_ready = 1'b1;
        wait_done("e");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
